axi4_ddr_bram_responder: RTL

// AXI4 subordinate (responder) that answers one DDR M port of the AWSteria HW top (ddr_A_M_* / ddr_B_M_*).

---
 rtl/axi4_ddr_bram_responder.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_ddr_bram_responder.sv
// AXI4 responder backed by a block RAM. It stands in for one DDR port so the
// partition can run without a memory controller. Supports full-width INCR and
// FIXED bursts with byte strobes. The read and write paths are independent, and
// each path allows one outstanding burst.
//
// Handshake rule for every AXI channel: a transfer happens on a rising CLK edge
// where valid and ready are both 1. A source that raises valid holds it, and the
// payload stays stable, until that edge. Ready may come before or after valid.
module axi4_ddr_bram_responder #(
  parameter int ID_W      = 6,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MEM_WORDS = 4096
) (
  input  logic                CLK,
  input  logic                RST_N,
  // read address
  input  logic                S_arvalid,
  output logic                S_arready,
  input  logic [ID_W-1:0]     S_arid,
  input  logic [ADDR_W-1:0]   S_araddr,
  input  logic [7:0]          S_arlen,
  input  logic [2:0]          S_arsize,
  input  logic [1:0]          S_arburst,
  input  logic [3:0]          S_arcache,
  input  logic                S_arlock,
  input  logic [2:0]          S_arprot,
  input  logic [3:0]          S_arqos,
  input  logic [3:0]          S_arregion,
  // write address
  input  logic                S_awvalid,
  output logic                S_awready,
  input  logic [ID_W-1:0]     S_awid,
  input  logic [ADDR_W-1:0]   S_awaddr,
  input  logic [7:0]          S_awlen,
  input  logic [2:0]          S_awsize,
  input  logic [1:0]          S_awburst,
  input  logic [3:0]          S_awcache,
  input  logic                S_awlock,
  input  logic [2:0]          S_awprot,
  input  logic [3:0]          S_awqos,
  input  logic [3:0]          S_awregion,
  // write data
  input  logic                S_wvalid,
  output logic                S_wready,
  input  logic [DATA_W-1:0]   S_wdata,
  input  logic [DATA_W/8-1:0] S_wstrb,
  input  logic                S_wlast,
  // write response
  output logic                S_bvalid,
  input  logic                S_bready,
  output logic [ID_W-1:0]     S_bid,
  output logic [1:0]          S_bresp,
  // read data
  output logic                S_rvalid,
  input  logic                S_rready,
  output logic [ID_W-1:0]     S_rid,
  output logic [1:0]          S_rresp,
  output logic [DATA_W-1:0]   S_rdata,
  output logic                S_rlast,
  // FSM state visibility
  output logic [1:0]          dbg_rd_state,
  output logic [1:0]          dbg_wr_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LOG2S  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_BURST = 2'd1;
  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // Decide the response of a whole burst when its address is accepted.
  // Out-of-range wins over a bad size or burst type.
  function automatic logic [1:0] classify(input logic [ADDR_W-1:0] addr,
                                          input logic [7:0] len,
                                          input logic [2:0] size,
                                          input logic [1:0] burst);
    logic [ADDR_W:0] last_idx;
    last_idx = {1'b0, addr >> LOG2S} + {{(ADDR_W-7){1'b0}}, len};
    if (last_idx >= (ADDR_W+1)'(MEM_WORDS)) return RESP_DECERR;
    if (size != 3'(LOG2S) || (burst != BURST_FIXED && burst != BURST_INCR)) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [1:0]       rd_state;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_len;
  logic [7:0]       rd_cnt;
  logic             rd_issue_done;
  logic             rd_fixed;
  logic             ren;
  logic             ar_fire;
  logic             r_fire;

  logic [1:0]       wr_state;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_len;
  logic [7:0]       wr_cnt;
  logic             wr_fixed;
  logic             wr_err;
  logic             aw_fire;
  logic             w_fire;

  logic             unused_ok;

  assign ar_fire = S_arvalid && S_arready;
  assign r_fire  = S_rvalid && S_rready;
  assign aw_fire = S_awvalid && S_awready;
  assign w_fire  = S_wvalid && S_wready;

  // A RAM read is issued only when the output register is empty or being
  // drained, so a stalled beat simply holds in the RAM output register.
  assign ren = (rd_state == R_BURST) && !rd_issue_done && (!S_rvalid || S_rready);

  assign S_wready     = (wr_state == W_DATA);
  assign dbg_rd_state = rd_state;
  assign dbg_wr_state = wr_state;

  assign unused_ok = ^{S_arcache, S_arlock, S_arprot, S_arqos, S_arregion,
                       S_awcache, S_awlock, S_awprot, S_awqos, S_awregion};

  // Read FSM: accept AR, issue one RAM read per beat, track rvalid/rlast.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_state      <= R_IDLE;
      S_arready     <= 1'b0;
      S_rvalid      <= 1'b0;
      S_rlast       <= 1'b0;
      S_rid         <= '0;
      S_rresp       <= RESP_OKAY;
      rd_idx        <= '0;
      rd_len        <= '0;
      rd_cnt        <= '0;
      rd_issue_done <= 1'b0;
      rd_fixed      <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          S_arready <= 1'b1;
          if (ar_fire) begin
            rd_state      <= R_BURST;
            S_arready     <= 1'b0;
            S_rid         <= S_arid;
            S_rresp       <= classify(S_araddr, S_arlen, S_arsize, S_arburst);
            rd_idx        <= S_araddr[LOG2S +: IDX_W];
            rd_len        <= S_arlen;
            rd_cnt        <= '0;
            rd_issue_done <= 1'b0;
            rd_fixed      <= (S_arburst == BURST_FIXED);
          end
        end
        R_BURST: begin
          if (ren) begin
            S_rvalid <= 1'b1;
            S_rlast  <= (rd_cnt == rd_len);
            if (rd_cnt == rd_len) rd_issue_done <= 1'b1;
            else                  rd_cnt        <= rd_cnt + 8'd1;
            if (!rd_fixed) rd_idx <= rd_idx + IDX_ONE;
          end else if (r_fire) begin
            S_rvalid <= 1'b0;
          end
          if (r_fire && S_rlast) begin
            rd_state  <= R_IDLE;
            S_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // RAM read port with output register; error bursts return zero data.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      S_rdata <= '0;
    end else if (ren) begin
      S_rdata <= (S_rresp == RESP_OKAY) ? mem[rd_idx] : '0;
    end
  end

  // Write FSM: accept AW, count len+1 beats, then hold B until bready.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_state  <= W_IDLE;
      S_awready <= 1'b0;
      S_bvalid  <= 1'b0;
      S_bid     <= '0;
      S_bresp   <= RESP_OKAY;
      wr_idx    <= '0;
      wr_len    <= '0;
      wr_cnt    <= '0;
      wr_fixed  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          S_awready <= 1'b1;
          if (aw_fire) begin
            wr_state  <= W_DATA;
            S_awready <= 1'b0;
            S_bid     <= S_awid;
            S_bresp   <= classify(S_awaddr, S_awlen, S_awsize, S_awburst);
            wr_err    <= (classify(S_awaddr, S_awlen, S_awsize, S_awburst) != RESP_OKAY);
            wr_idx    <= S_awaddr[LOG2S +: IDX_W];
            wr_len    <= S_awlen;
            wr_cnt    <= '0;
            wr_fixed  <= (S_awburst == BURST_FIXED);
          end
        end
        W_DATA: begin
          if (w_fire) begin
            // wlast misplacement is reported but the beat count still rules
            if ((S_wlast != (wr_cnt == wr_len)) && (S_bresp == RESP_OKAY)) S_bresp <= RESP_SLVERR;
            if (!wr_fixed) wr_idx <= wr_idx + IDX_ONE;
            if (wr_cnt == wr_len) begin
              wr_state <= W_RESP;
              S_bvalid <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (S_bready) begin
            S_bvalid  <= 1'b0;
            wr_state  <= W_IDLE;
            S_awready <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // RAM write port: byte-enabled writes, skipped for error bursts.
  always_ff @(posedge CLK) begin
    if (w_fire && !wr_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_wstrb[b]) mem[wr_idx][b*8 +: 8] <= S_wdata[b*8 +: 8];
      end
    end
  end

endmodule
